// File: rtl/axi_wr_burst_gen_if.sv
// axi_wr_burst_gen_if: command, write-data stream, AXI write channels and status of the burst generator
interface axi_wr_burst_gen_if #(parameter int AW = 32, parameter int DW = 64);
  logic          cmd_valid, cmd_ready;
  logic [AW-1:0] cmd_addr;
  logic [7:0]    cmd_len;
  logic [2:0]    cmd_size;
  logic [1:0]    cmd_burst;
  logic            din_valid, din_ready;
  logic [DW-1:0]   din_data;
  logic [DW/8-1:0] din_strb;
  logic [AW-1:0] awaddr;
  logic [7:0]    awlen;
  logic [2:0]    awsize;
  logic [1:0]    awburst;
  logic          awvalid, awready;
  logic [DW-1:0]   wdata;
  logic [DW/8-1:0] wstrb;
  logic            wvalid, wready, wlast;
  logic       bready, bvalid;
  logic [1:0] bresp;
  logic       busy, done, err;
  logic [1:0] last_resp;
  modport master (
    input  cmd_valid, cmd_addr, cmd_len, cmd_size, cmd_burst, din_valid, din_data, din_strb,
           awready, wready, bvalid, bresp,
    output cmd_ready, din_ready, awaddr, awlen, awsize, awburst, awvalid,
           wdata, wstrb, wvalid, wlast, bready, busy, done, err, last_resp
  );
  modport slave (
    output cmd_valid, cmd_addr, cmd_len, cmd_size, cmd_burst, din_valid, din_data, din_strb,
           awready, wready, bvalid, bresp,
    input  cmd_ready, din_ready, awaddr, awlen, awsize, awburst, awvalid,
           wdata, wstrb, wvalid, wlast, bready, busy, done, err, last_resp
  );
endinterface

// File: rtl/axi_wr_burst_gen.sv
// axi_wr_burst_gen: issues one AXI write burst per command, feeding W beats from a small data FIFO
module axi_wr_burst_gen #(
  parameter int AW = 32,
  parameter int DW = 64,
  parameter int FD = 4
) (
  input logic clk,
  input logic rst,
  axi_wr_burst_gen_if.master bus
);
  localparam int PW = $clog2(FD);
  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;
  state_t          state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [7:0]      len_q, len_d, beat_q, beat_d;
  logic [2:0]      size_q, size_d;
  logic [1:0]      burst_q, burst_d, resp_q, resp_d;
  logic [DW-1:0]   dmem [FD];
  logic [DW/8-1:0] smem [FD];
  logic [PW-1:0]   wp_q, rp_q;
  logic [PW:0]     cnt_q;
  logic            full, empty, push, pop, wvalid, wlast;
  assign full   = cnt_q == (PW+1)'(FD);
  assign empty  = cnt_q == '0;
  assign push   = bus.din_valid && !full;
  assign wvalid = state_q == DATA && !empty;
  assign wlast  = wvalid && beat_q == len_q;
  assign pop    = wvalid && bus.wready;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) wp_q <= wp_q + PW'(1);
      if (pop) rp_q <= rp_q + PW'(1);
      cnt_q <= cnt_q + (PW+1)'(push) - (PW+1)'(pop);
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      dmem[wp_q] <= bus.din_data;
      smem[wp_q] <= bus.din_strb;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      size_q  <= '0;
      burst_q <= '0;
      beat_q  <= '0;
      resp_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      size_q  <= size_d;
      burst_q <= burst_d;
      beat_q  <= beat_d;
      resp_q  <= resp_d;
    end
  end
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    len_d   = len_q;
    size_d  = size_q;
    burst_d = burst_q;
    beat_d  = beat_q;
    resp_d  = resp_q;
    case (state_q)
      IDLE: if (bus.cmd_valid) begin
        addr_d  = bus.cmd_addr;
        len_d   = bus.cmd_len;
        size_d  = bus.cmd_size;
        burst_d = bus.cmd_burst;
        beat_d  = '0;
        state_d = ADDR;
      end
      ADDR: state_d = bus.awready ? DATA : ADDR;
      // the counter holds on the last beat so len=255 never wraps past len
      DATA: if (pop) begin
        beat_d  = wlast ? beat_q : beat_q + 8'd1;
        state_d = wlast ? RESP : DATA;
      end
      RESP: if (bus.bvalid) begin
        resp_d  = bus.bresp;
        state_d = IDLE;
      end
    endcase
  end
  assign bus.cmd_ready = state_q == IDLE;
  assign bus.din_ready = !full;
  assign bus.awvalid   = state_q == ADDR;
  assign bus.awaddr    = addr_q;
  assign bus.awlen     = len_q;
  assign bus.awsize    = size_q;
  assign bus.awburst   = burst_q;
  assign bus.wvalid    = wvalid;
  assign bus.wlast     = wlast;
  assign bus.wdata     = dmem[rp_q];
  assign bus.wstrb     = smem[rp_q];
  assign bus.bready    = state_q == RESP;
  assign bus.done      = state_q == RESP && bus.bvalid;
  assign bus.err       = bus.done && bus.bresp != 2'b00;
  assign bus.busy      = state_q != IDLE;
  assign bus.last_resp = resp_q;
endmodule

// File: doc/axi_wr_burst_gen.md
AXI_WR_BURST_GEN -- requirements
Module: axi_wr_burst_gen

Interface
REQ-001 Parameter AW, default 32, address width.
REQ-002 Parameter DW, default 64, write data width; strobe width is DW/8.
REQ-003 Parameter FD, default 4, data FIFO depth; power of two, minimum 2.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 cmd_valid/cmd_ready  in/out  1/1  burst command handshake.
REQ-007 cmd_addr/cmd_len/cmd_size/cmd_burst  in  AW/8/3/2  command fields; beats = cmd_len+1.
REQ-008 din_valid/din_ready  in/out  1/1  write-data stream handshake.
REQ-009 din_data/din_strb  in  DW/DW/8  write-data beat.
REQ-010 awaddr/awlen/awsize/awburst  out  AW/8/3/2  feed the write channel's address inputs.
REQ-011 awvalid out 1; awready in 1  address handshake.
REQ-012 wdata/wstrb  out  DW/DW/8; wvalid out 1; wready in 1; wlast out 1  data handshake.
REQ-013 bready out 1; bvalid in 1; bresp in 2  response handshake.
REQ-014 busy out 1; done out 1 (one-cycle pulse); err out 1 (one-cycle pulse, with done); last_resp out 2.

Function
REQ-015 The block SHALL use FSM states IDLE, ADDR, DATA, RESP.
REQ-016 In IDLE, cmd_ready SHALL be 1; on cmd_valid&&cmd_ready, the block SHALL register all command fields, clear the beat counter, and enter ADDR.
REQ-017 In ADDR, awvalid SHALL be 1 with registered fields held stable; on awvalid&&awready, the block SHALL enter DATA.
REQ-018 awvalid SHALL NOT deassert until awready is sampled high.
REQ-019 The data FIFO SHALL accept din while not full (din_ready = !full) in every state, including IDLE.
REQ-020 In DATA, wvalid SHALL equal FIFO not-empty, and wdata/wstrb SHALL be the FIFO head.
REQ-021 Each wvalid&&wready SHALL pop one FIFO entry and increment the 8-bit beat counter.
REQ-022 wlast SHALL be 1 exactly when wvalid is 1 and beat counter == registered len.
REQ-023 Once asserted, wvalid SHALL stay high with stable data until wready; the head cannot change while wvalid is high.
REQ-024 When the beat with wlast is accepted, the block SHALL enter RESP.
REQ-025 When len=255, the counter SHALL reach 255 without wrap and SHALL NOT exceed len.
REQ-026 A simultaneous push and pop on the FIFO SHALL keep the count unchanged; a push to a full FIFO SHALL be impossible (din_ready=0).
REQ-027 FIFO pointers SHALL wrap modulo FD; the count SHALL be log2(FD)+1 bits.
REQ-028 In RESP, bready SHALL be 1; on bvalid, the block SHALL capture bresp into last_resp, pulse done, pulse err if bresp != 2'b00, and return to IDLE.
REQ-029 bready SHALL be 0 outside RESP, and awvalid SHALL be 0 outside ADDR.
REQ-030 busy SHALL be 1 in any state other than IDLE.
REQ-031 A new command SHALL be accepted only in IDLE, so a command is never accepted in the cycle that done is high.
REQ-032 Data pushed beyond the current burst SHALL remain in the FIFO for the next burst.

Reset
REQ-033 While rst is high: state=IDLE; awvalid, wvalid, wlast, bready, done, err = 0; last_resp=0; FIFO empty; counter=0; registered command fields=0.
REQ-034 Reset mid-burst SHALL abort immediately, discarding FIFO contents; after release, cmd_ready=1 in the first cycle.
REQ-035 After rst deasserts, outputs SHALL change only on clk edges.

Verification
REQ-036 Single beat: cmd addr=0x1000 len=0 size=3 burst=1; 1 din beat; awready=wready=1; bvalid with bresp=0 -> one AW at 0x1000, one W with wlast=1, done=1 with err=0, total 4 cycles from command to IDLE.
REQ-037 Backpressure: len=3, awready low 3 cycles, wready toggling -> awvalid held stable, 4 W beats in order, wlast only on the 4th beat, data unchanged while stalled.
REQ-038 Starved data: len=7, din arrives one beat every 3 cycles -> wvalid drops between beats, no beat lost or duplicated, wlast on beat 8.
REQ-039 Error response: bresp=2'b10 -> done=1 and err=1 in the same cycle, last_resp=2'b10, FSM returns to IDLE.
REQ-040 Max burst plus FIFO full: len=255, wready low while din pushes -> din_ready=0 after FD entries, 256 beats complete, counter never wraps.
REQ-041 Reset mid-DATA: assert rst after beat 2 of len=3 -> awvalid/wvalid/bready=0 immediately, FIFO empty, cmd_ready=1 after release.
